// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU and the ALU controller: operation
// encoding, execute-unit FSM states and default datapath width.
package alu_pkg;

  localparam int ALU_DATA_WIDTH_DEF = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_SRA = 4'b0111,
    ALU_EQ  = 4'b1000,
    ALU_SLT = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift engine for alu_iterative: one bit per cycle by default, or a purely
// combinational barrel shifter when ALU_BARREL_SHIFT_EN is defined.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH_DEF,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  step,
  input  alu_op_e               kind,
  input  logic [DATA_WIDTH-1:0] operand,
  input  logic [SHAMT_W-1:0]    amount,
  output logic [DATA_WIDTH-1:0] shift_result,
  output logic                  last_step
);

`ifdef ALU_BARREL_SHIFT_EN

  always_comb begin
    shift_result = operand;
    case (kind)
      ALU_SLL: shift_result = operand << amount;
      ALU_SRL: shift_result = operand >> amount;
      ALU_SRA: shift_result = $signed(operand) >>> amount;
      default: shift_result = operand;
    endcase
  end

  assign last_step = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst_n, flush, load, step};

`else

  logic [DATA_WIDTH-1:0] operand_q, operand_d;
  logic [SHAMT_W-1:0]    count_q, count_d;
  alu_op_e               kind_q, kind_d;
  logic                  fill_bit;

  // shift_result is the operand advanced by one more bit, so the top can
  // register the final value on the same edge the count runs out.
  always_comb begin
    fill_bit     = (kind_q == ALU_SRA) & operand_q[DATA_WIDTH-1];
    shift_result = (kind_q == ALU_SLL) ? {operand_q[DATA_WIDTH-2:0], 1'b0}
                                       : {fill_bit, operand_q[DATA_WIDTH-1:1]};
    last_step    = (count_q == SHAMT_W'(1));
  end

  always_comb begin
    operand_d = operand_q;
    count_d   = count_q;
    kind_d    = kind_q;
    if (flush) begin
      count_d = '0;
    end else if (load) begin
      operand_d = operand;
      count_d   = amount;
      kind_d    = kind;
    end else if (step && (count_q != '0)) begin
      operand_d = shift_result;
      count_d   = count_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_q <= '0;
      count_q   <= '0;
      kind_q    <= ALU_SLL;
    end else begin
      operand_q <= operand_d;
      count_q   <= count_d;
      kind_q    <= kind_d;
    end
  end

`endif

endmodule

// File: rtl/alu_iterative.sv
// EX-stage execute unit with valid/ready handshake and a registered result.
// Shifts iterate one bit per cycle unless ALU_BARREL_SHIFT_EN is defined.
module alu_iterative
  import alu_pkg::*;
#(
  parameter  int DATA_WIDTH = ALU_DATA_WIDTH_DEF,
  localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  alu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;

  alu_op_e               op;
  logic [SHAMT_W-1:0]    shamt;
  logic                  accept;
  logic                  start_shift;
  logic                  sh_load, sh_step, sh_last;
  logic [DATA_WIDTH-1:0] sh_result;
  logic [DATA_WIDTH-1:0] comb_result;

  assign op    = alu_op_e'(Operation);
  assign shamt = SrcB[SHAMT_W-1:0];

  assign in_ready  = !flush && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign ALUResult = result_q;
  assign Zero      = zero_q;

`ifdef ALU_BARREL_SHIFT_EN
  assign start_shift = 1'b0;
`else
  assign start_shift = is_shift_op(op) && (shamt != '0);
`endif

  alu_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_W    (SHAMT_W)
  ) u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .load         (sh_load),
    .step         (sh_step),
    .kind         (op),
    .operand      (SrcA),
    .amount       (shamt),
    .shift_result (sh_result),
    .last_step    (sh_last)
  );

  always_comb begin
    comb_result = '0;
    case (op)
      ALU_AND: comb_result = SrcA & SrcB;
      ALU_OR:  comb_result = SrcA | SrcB;
      ALU_ADD: comb_result = SrcA + SrcB;
      ALU_SUB: comb_result = SrcA - SrcB;
      ALU_XOR: comb_result = SrcA ^ SrcB;
      ALU_EQ:  comb_result = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      ALU_SLT: comb_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL, ALU_SRL, ALU_SRA: comb_result = sh_result;
`else
      // Only zero-amount shifts take the single-cycle path.
      ALU_SLL, ALU_SRL, ALU_SRA: comb_result = SrcA;
`endif
      default: comb_result = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    sh_load  = 1'b0;
    sh_step  = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (start_shift) begin
              sh_load = 1'b1;
              state_d = ST_SHIFT;
            end else begin
              result_d = comb_result;
              state_d  = ST_DONE;
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_d = ST_IDLE;
          end
        end
`ifndef ALU_BARREL_SHIFT_EN
        ST_SHIFT: begin
          sh_step = 1'b1;
          if (sh_last) begin
            result_d = sh_result;
            state_d  = ST_DONE;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed self-checking bench for alu_iterative; shift latencies follow
// ALU_BARREL_SHIFT_EN when the build defines it.
module tb_alu_iterative;
  import alu_pkg::*;

`ifdef ALU_BARREL_SHIFT_EN
  localparam int ITER = 0;
`else
  localparam int ITER = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, Zero;
  logic [3:0]  Operation;
  logic [31:0] SrcA, SrcB, ALUResult;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_iterative #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Present one request, scramble the inputs after accept, then measure how
  // many sampling points pass before out_valid appears.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int waited;
    int lat;
    @(negedge clk);
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk); #1; waited++;
    end
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; SrcA = ~a; SrcB = ~b;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk); lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_result"}, ALUResult, exp);
    check_eq({tag, "_zero"}, 32'(Zero), 32'(exp == 32'd0));
    $display("op %-8s A=0x%08h B=0x%08h result=0x%08h zero=%0d latency=%0d",
             tag, a, b, ALUResult, Zero, lat);
  endtask

  logic [31:0] sa [8];
  logic [31:0] sb [8];
  logic [31:0] se [8];
  logic [15:0] pat;

  initial begin
    int  tx, rx, cyc;
    bit  fire_in, held_v, seen;
    logic [31:0] held;

    sa = '{32'h10, 32'h0, 32'h100, 32'h8000_0000, 32'h1234, 32'hFFFF_FFFF, 32'h5, 32'h7FFF_FFFF};
    sb = '{32'h3,  32'h1, 32'h100, 32'h1,         32'h234,  32'hFFFF_FFFF, 32'hA, 32'hFFFF_FFFF};
    se = '{32'hD,  32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF, 32'h1000, 32'h0, 32'hFFFF_FFFB, 32'h8000_0000};
    pat = 16'b1011_0010_1110_0101;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Operation = 4'h0; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", ALUResult, 32'd0);
    check_eq("rst_zero", 32'(Zero), 32'd1);
    rst_n = 1'b1;
    #1;
    check_eq("idle_in_ready", 32'(in_ready), 32'd1);

    run_op("add_wrap", 4'b0010, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0, 1);
    run_op("slt_neg",  4'b1100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1, 1);
    run_op("slt_pos",  4'b1100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1);
    run_op("eq_same",  4'b1000, 32'h0000_1234, 32'h0000_1234, 32'h1, 1);
    run_op("eq_diff",  4'b1000, 32'h0000_1234, 32'h0000_1235, 32'h0, 1);
    run_op("undef_f",  4'b1111, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 1);
    run_op("undef_9",  4'b1001, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 1);
    run_op("and",      4'b0000, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1);
    run_op("or",       4'b0001, 32'hF0F0_0000, 32'h0F00_000F, 32'hFFF0_000F, 1);
    run_op("sub_neg",  4'b0011, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1);
    run_op("sra31",    4'b0111, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1 + ITER * 31);
    run_op("sll0",     4'b0101, 32'hA5A5_0001, 32'h0000_0020, 32'hA5A5_0001, 1);
    run_op("sll4",     4'b0101, 32'h8000_0001, 32'h0000_0004, 32'h0000_0010, 1 + ITER * 4);
    run_op("srl4",     4'b0110, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 1 + ITER * 4);
    run_op("sra1_pos", 4'b0111, 32'h4000_0002, 32'h0000_0001, 32'h2000_0001, 1 + ITER * 1);

    // Streamed SUBs against a fixed out_ready pattern.
    tx = 0; rx = 0; cyc = 0; fire_in = 1'b0; held_v = 1'b0; held = '0;
    while (rx < 8 && cyc < 300) begin
      @(negedge clk);
      if (fire_in) tx++;
      out_ready = pat[cyc % 16];
      Operation = 4'b0011;
      if (tx < 8) begin
        in_valid = 1'b1; SrcA = sa[tx]; SrcB = sb[tx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held_v) begin
        check_eq("stall_hold", ALUResult, held);
        held_v = 1'b0;
      end
      fire_in = in_valid && in_ready;
      if (out_valid) begin
        if (out_ready) begin
          check_eq($sformatf("stream_sub%0d", rx), ALUResult, se[rx]);
          $display("op stream%0d result=0x%08h expected=0x%08h cycle=%0d", rx, ALUResult, se[rx], cyc);
          rx++;
        end else begin
          held = ALUResult; held_v = 1'b1;
        end
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_eq("stream_count", 32'(rx), 32'd8);
    @(negedge clk);
    check_eq("stream_no_extra", 32'(out_valid), 32'd0);

    // Flush with a request presented in IDLE: nothing is accepted.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; Operation = 4'b0010; SrcA = 32'h1; SrcB = 32'h1;
    #1;
    check_eq("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_no_accept", 32'(out_valid), 32'd0);

    // Flush five cycles into SRL by 20.
    @(negedge clk);
    Operation = 4'b0110; SrcA = 32'hF000_0000; SrcB = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check_eq("flush_idle", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("flush_no_valid", 32'(seen), 32'd0);
    run_op("add_post", 4'b0010, 32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 1);

    // Reset pulse in the middle of SLL by 20.
    @(negedge clk);
    Operation = 4'b0101; SrcA = 32'h1; SrcB = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_result", ALUResult, 32'd0);
    check_eq("midrst_zero", 32'(Zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_idle", 32'(in_ready), 32'd1);
    run_op("xor_post", 4'b0100, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Multi-cycle execute unit that consumes the 4-bit `Operation` code produced by the ALU controller, together with two operands, and returns a registered result over a valid/ready handshake. Logical, arithmetic and compare operations complete in one cycle. Shifts run through an iterative shifter at one bit per cycle. The block sits in the EX stage and lets the pipeline stall on long shifts instead of paying for a full barrel shifter.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand and result width; must be a power of two ≥ 8.
- `SHAMT_W`, $clog2(DATA_WIDTH), shift-amount width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort of the in-flight operation.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid && in_ready` at a rising edge.
- `Operation`  in  4  operation code, encoding below.
- `SrcA`  in  DATA_WIDTH  operand A.
- `SrcB`  in  DATA_WIDTH  operand B; `SrcB[SHAMT_W-1:0]` is the shift amount.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid && out_ready` at a rising edge.
- `ALUResult`  out  DATA_WIDTH  registered result.
- `Zero`  out  1  registered, equals `ALUResult == 0`.

## Operation
Encoding:
- 0000 AND.
- 0001 OR.
- 0010 ADD.
- 0011 SUB.
- 0100 XOR.
- 0101 SLL.
- 0110 SRL.
- 0111 SRA.
- 1000 EQ: result 1 if `SrcA == SrcB`, else 0.
- 1100 SLT: signed compare; result 1 if `SrcA < SrcB`, else 0.
- Any other code: result 0, completes in one cycle.

Arithmetic:
- ADD and SUB wrap modulo 2^DATA_WIDTH; no overflow flag.
- SRA replicates the captured `SrcA` MSB.

State machine (IDLE, SHIFT, DONE):
- IDLE, on accept:
  - Shift with amount ≠ 0 → SHIFT; operand and count = amount are latched.
  - Anything else → DONE, result computed and registered.
- SHIFT: each cycle shifts the operand by one bit and decrements the count. When the count reaches 1 at an edge, the final shifted value is registered → DONE.
- DONE:
  - `out_valid` = 1.
  - On `out_ready`: accept a new request if one is presented (same rules as IDLE), otherwise → IDLE.
  - Without `out_ready`: hold the result stable.
- `in_ready` = (state == IDLE) || (state == DONE && out_ready). It is combinational and does not depend on `in_valid`.
- `flush` = 1: next state is IDLE and `out_valid` drops next cycle. A request presented in the same cycle is not accepted and `in_ready` reads 0. Flush takes priority over every other transition.
- Operands are captured at accept; later input changes do not affect the in-flight operation.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State = IDLE, `out_valid` = 0, `ALUResult` = 0, `Zero` = 1, shift count = 0.
  - No transfer occurs while `rst_n` is low.
- Non-shift op, or shift by 0, accepted at edge N: `out_valid` = 1 after edge N+1.
- Shift by k (1 ≤ k ≤ DATA_WIDTH−1) accepted at edge N: `out_valid` = 1 after edge N+1+k.
- Back-to-back single-cycle ops with `out_ready` held high sustain one result per cycle.
- Reset asserted mid-shift: the operation is discarded immediately.
- Deasserting `out_ready` freezes `ALUResult` and `Zero` with no bubbles or loss.

## Configuration
- `ALU_BARREL_SHIFT_EN` defined:
  - SLL, SRL and SRA use a combinational barrel shifter and complete in one cycle like other ops.
  - The SHIFT state and shift counter are not compiled.
- Undefined: iterative one-bit-per-cycle shifter as described above.
- Handshake and port list are identical in both builds.

## Structure
- Shared package `alu_pkg` holds:
  - `alu_op_e` (4-bit enum of the encodings above).
  - `alu_state_e` (IDLE, SHIFT, DONE).
  - `ALU_DATA_WIDTH_DEF` = 32.
- The ALU controller imports `alu_op_e` so both ends share one encoding.
- Sub-module `alu_shifter`:
  - Implements the iterative shifter: load, step, count, done.
  - Compiles to a barrel shifter under `ALU_BARREL_SHIFT_EN`.
  - `alu_iterative` owns the handshake and the result register.

## Test plan
- Reset, then ADD 0x0000_0005 + 0xFFFF_FFFB → `ALUResult` 0, `Zero` 1, `out_valid` one cycle after accept.
- SLT 0xFFFF_FFFF vs 0x0000_0001 → 1; EQ 0x1234 vs 0x1234 → 1; undefined code 1111 → 0.
- SRA 0x8000_0000 by 31 → 0xFFFF_FFFF with `out_valid` 32 cycles after accept; SLL by 0 → result in 1 cycle. With `ALU_BARREL_SHIFT_EN` defined, both shifts complete in 1 cycle.
- Stream 8 SUBs with `out_ready` toggling pseudo-randomly → every result delivered in order, none dropped or duplicated, `ALUResult` stable while stalled.
- Assert `flush` mid-SHIFT (SRL by 20, flush after 5 cycles) → IDLE next cycle, `out_valid` never asserts for that op, and the next ADD completes normally.
- Assert `rst_n` low mid-shift for 1 cycle → outputs at reset values immediately; after release, XOR 0xF0F0 ^ 0x0FF0 → 0xFF00.
